// File: rtl/harvos_exec_pkg.sv
// Shared types for the executable-PPN tracker control path.
// Consumers: exec_ppn_fifo, exec_ppn_insert_ctrl.
package harvos_exec_pkg;

    localparam int PPN_W      = 20;
    localparam int PAGE_SHIFT = 12;

    typedef logic [PPN_W-1:0] ppn_t;

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        INSERT,
        DROP,
        CLEAR
    } ctrl_state_e;

endpackage

// File: rtl/exec_ppn_fifo.sv
// Pending-insert FIFO: DEPTH x PPN_W, synchronous push/pop with flush.
// Pointers carry one extra bit so full and empty are distinguishable.
module exec_ppn_fifo #(
    parameter int PPN_W = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [PPN_W-1:0] din,
    output logic [PPN_W-1:0] head,
    output logic             full,
    output logic             empty
);
    import harvos_exec_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [PPN_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot, so push on full is still legal.
    assign push_ok = push && (!full || pop_ok) && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // entries are valid, and sequential state always uses non-blocking assignment.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/exec_ppn_insert_ctrl.sv
// Executable-PPN tracker sequencer: arbitrates ITLB/PTW inserts into a FIFO, drains
// them to the tracker, owns its clear. `HARVOS_EXEC_PPN_DEDUP_EN adds probe-before-insert.
module exec_ppn_insert_ctrl #(
    parameter int PPN_W      = 20,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             itlb_valid_i,
    output logic             itlb_ready_o,
    input  logic [PPN_W-1:0] itlb_ppn_i,
    input  logic             itlb_x_i,
    input  logic             ptw_valid_i,
    output logic             ptw_ready_o,
    input  logic [PPN_W-1:0] ptw_ppn_i,
    input  logic             ptw_x_i,
    input  logic             sfence_g_i,
    input  logic             satp_wr_i,
    input  logic             fq_valid_i,
    input  logic [31:0]      fq_pa_i,
    output logic             fq_ready_o,
    output logic             fq_hit_o,
    output logic             trk_clear_o,
    output logic             trk_insert_o,
    output logic [PPN_W-1:0] trk_ppn_o,
    output logic [31:0]      trk_qpa_o,
    input  logic             trk_hit_i,
    output logic             busy_o
);
    import harvos_exec_pkg::*;

    ctrl_state_e      state;
    ctrl_state_e      state_nx;
    logic             clr;
    logic             rr_itlb;
    logic             grant_itlb;
    logic             grant_ptw;
    logic             can_accept;
    logic             accept;
    logic             push;
    logic             pop;
    logic             win_x;
    logic [PPN_W-1:0] win_ppn;
    logic [PPN_W-1:0] head_ppn;
    logic             fifo_full;
    logic             fifo_empty;
    logic             probe_grant;

    assign clr = sfence_g_i | satp_wr_i;

    // Round-robin only breaks ties; a lone requester always wins.
    assign grant_itlb   = itlb_valid_i && (!ptw_valid_i || rr_itlb);
    assign grant_ptw    = ptw_valid_i && (!itlb_valid_i || !rr_itlb);
    assign can_accept   = !fifo_full && !clr && (state != CLEAR);
    assign itlb_ready_o = grant_itlb && can_accept;
    assign ptw_ready_o  = grant_ptw && can_accept;
    assign accept       = itlb_ready_o || ptw_ready_o;
    assign win_x        = grant_itlb ? itlb_x_i : ptw_x_i;
    assign win_ppn      = grant_itlb ? itlb_ppn_i : ptw_ppn_i;
    assign push         = accept && win_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_itlb <= 1'b1;
        end else if (accept) begin
            rr_itlb <= ~rr_itlb;
        end
    end

    exec_ppn_fifo #(
        .PPN_W (PPN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (clr),
        .din   (win_ppn),
        .head  (head_ppn),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef HARVOS_EXEC_PPN_DEDUP_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    // A probe never overlaps a clear: its answer would refer to a CAM about to be wiped.
    assign probe_grant = (state == PROBE) && !clr &&
                         (!fq_valid_i || (starve_cnt >= SW'(STARVE_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (clr || probe_grant) begin
            starve_cnt <= '0;
        end else if (state == PROBE) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Without probes the starvation limit has nothing to bound.
    logic unused_starve_max;
    assign unused_starve_max = ^32'(STARVE_MAX);
    assign probe_grant       = 1'b0;
`endif

    always_comb begin
        trk_qpa_o  = fq_pa_i;
        fq_ready_o = fq_valid_i;
        fq_hit_o   = trk_hit_i;
        if (probe_grant) begin
            trk_qpa_o  = 32'({head_ppn, {PAGE_SHIFT{1'b0}}});
            fq_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        trk_insert_o = 1'b0;
        trk_clear_o  = 1'b0;
        case (state)
            IDLE: begin
`ifdef HARVOS_EXEC_PPN_DEDUP_EN
                if (!fifo_empty) state_nx = PROBE;
`else
                if (!fifo_empty) state_nx = INSERT;
`endif
            end
`ifdef HARVOS_EXEC_PPN_DEDUP_EN
            PROBE: begin
                if (probe_grant) state_nx = trk_hit_i ? DROP : INSERT;
            end
            DROP: begin
                pop      = 1'b1;
                state_nx = IDLE;
            end
`endif
            INSERT: begin
                trk_insert_o = 1'b1;
                pop          = 1'b1;
                state_nx     = IDLE;
            end
            CLEAR: begin
                trk_clear_o = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A clear overrides any insert or pop decided above.
        if (clr) begin
            state_nx     = CLEAR;
            trk_insert_o = 1'b0;
            pop          = 1'b0;
        end
    end

    assign trk_ppn_o = trk_insert_o ? head_ppn : '0;
    assign busy_o    = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_exec_ppn_insert_ctrl.sv
// Self-checking bench for exec_ppn_insert_ctrl: directed scenarios plus random traffic,
// each cycle compared against a queue-based reference model of the controller's rules.
module tb_exec_ppn_insert_ctrl;
    import harvos_exec_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    localparam int PH_IDLE   = 0;
    localparam int PH_PROBE  = 1;
    localparam int PH_INSERT = 2;
    localparam int PH_DROP   = 3;
    localparam int PH_CLEAR  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        itlb_valid_i, itlb_x_i, ptw_valid_i, ptw_x_i;
    ppn_t        itlb_ppn_i, ptw_ppn_i;
    logic        sfence_g_i, satp_wr_i, fq_valid_i, trk_hit_i;
    logic [31:0] fq_pa_i;
    logic        itlb_ready_o, ptw_ready_o, fq_ready_o, fq_hit_o;
    logic        trk_clear_o, trk_insert_o, busy_o;
    ppn_t        trk_ppn_o;
    logic [31:0] trk_qpa_o;

    always #5 clk = ~clk;

    exec_ppn_insert_ctrl #(
        .PPN_W      (PPN_W),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .itlb_valid_i (itlb_valid_i),
        .itlb_ready_o (itlb_ready_o),
        .itlb_ppn_i   (itlb_ppn_i),
        .itlb_x_i     (itlb_x_i),
        .ptw_valid_i  (ptw_valid_i),
        .ptw_ready_o  (ptw_ready_o),
        .ptw_ppn_i    (ptw_ppn_i),
        .ptw_x_i      (ptw_x_i),
        .sfence_g_i   (sfence_g_i),
        .satp_wr_i    (satp_wr_i),
        .fq_valid_i   (fq_valid_i),
        .fq_pa_i      (fq_pa_i),
        .fq_ready_o   (fq_ready_o),
        .fq_hit_o     (fq_hit_o),
        .trk_clear_o  (trk_clear_o),
        .trk_insert_o (trk_insert_o),
        .trk_ppn_o    (trk_ppn_o),
        .trk_qpa_o    (trk_qpa_o),
        .trk_hit_i    (trk_hit_i),
        .busy_o       (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending inserts as a queue, drain phase, tie-break owner, probe wait.
    ppn_t pend[$];
    ppn_t cam[$];
    bit   m_rr_itlb = 1'b1;
    int   phase     = PH_IDLE;
    int   starve    = 0;

    function automatic bit cam_has(input ppn_t p);
        foreach (cam[i]) if (cam[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_rr_itlb = 1'b1;
        phase     = PH_IDLE;
        starve    = 0;
    endtask

    task automatic idle_inputs();
        itlb_valid_i = 1'b0; itlb_x_i = 1'b0; itlb_ppn_i = '0;
        ptw_valid_i  = 1'b0; ptw_x_i  = 1'b0; ptw_ppn_i  = '0;
        sfence_g_i   = 1'b0; satp_wr_i = 1'b0;
        fq_valid_i   = 1'b0; fq_pa_i   = '0; trk_hit_i = 1'b0;
    endtask

    // Called at a negedge with inputs applied; checks outputs, then advances one clock.
    task automatic step();
        bit          clr, can, g_i, g_p, e_ir, e_pr, acc, wx, probe, e_ins, e_fqr, hit;
        logic [31:0] e_qpa;
        ppn_t        wppn, e_ppn;
        clr   = sfence_g_i || satp_wr_i;
        can   = (pend.size() < DEPTH) && !clr && (phase != PH_CLEAR);
        g_i   = itlb_valid_i && (!ptw_valid_i || m_rr_itlb);
        g_p   = ptw_valid_i && !g_i;
        e_ir  = g_i && can;
        e_pr  = g_p && can;
        acc   = e_ir || e_pr;
        wx    = g_i ? itlb_x_i : ptw_x_i;
        wppn  = g_i ? itlb_ppn_i : ptw_ppn_i;
        probe = 1'b0;
`ifdef HARVOS_EXEC_PPN_DEDUP_EN
        probe = (phase == PH_PROBE) && !clr && (!fq_valid_i || starve >= STARVE_MAX);
`endif
        e_qpa = fq_pa_i;
        if (probe) e_qpa = {pend[0], 12'h000};
        e_fqr = fq_valid_i && !probe;
`ifdef HARVOS_EXEC_PPN_DEDUP_EN
        trk_hit_i = cam_has(e_qpa[31:12]);
`endif
        hit   = trk_hit_i;
        e_ins = (phase == PH_INSERT) && !clr;
        e_ppn = '0;
        if (e_ins) e_ppn = pend[0];
        #1;
        check("itlb_ready", itlb_ready_o, e_ir);
        check("ptw_ready", ptw_ready_o, e_pr);
        check("trk_clear", trk_clear_o, phase == PH_CLEAR);
        check("trk_insert", trk_insert_o, e_ins);
        check("trk_ppn", trk_ppn_o, e_ppn);
        check("trk_qpa", trk_qpa_o, e_qpa);
        check("fq_ready", fq_ready_o, e_fqr);
        check("fq_hit", fq_hit_o, hit);
        check("busy", busy_o, (pend.size() != 0) || (phase != PH_IDLE));
        @(posedge clk);
        if (phase == PH_CLEAR) cam.delete();
        if (clr) begin
            pend.delete();
            phase  = PH_CLEAR;
            starve = 0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (pend.size() != 0) begin
`ifdef HARVOS_EXEC_PPN_DEDUP_EN
                        phase = PH_PROBE;
`else
                        phase = PH_INSERT;
`endif
                    end
                end
                PH_PROBE: begin
                    if (probe) begin
                        starve = 0;
                        phase  = hit ? PH_DROP : PH_INSERT;
                    end else begin
                        starve++;
                    end
                end
                PH_INSERT: begin
                    cam.push_back(pend.pop_front());
                    phase = PH_IDLE;
                end
                PH_DROP: begin
                    void'(pend.pop_front());
                    phase = PH_IDLE;
                end
                default: phase = PH_IDLE;
            endcase
            if (acc) begin
                m_rr_itlb = !m_rr_itlb;
                if (wx) pend.push_back(wppn);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_itlb_ready"}, itlb_ready_o, 1'b0);
        check({tag, "_ptw_ready"}, ptw_ready_o, 1'b0);
        check({tag, "_trk_insert"}, trk_insert_o, 1'b0);
        check({tag, "_trk_clear"}, trk_clear_o, 1'b0);
        check({tag, "_trk_ppn"}, trk_ppn_o, 32'h0);
        check({tag, "_fq_ready"}, fq_ready_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single ITLB insert, fetch port idle.
        itlb_valid_i = 1'b1; itlb_ppn_i = 20'h12345; itlb_x_i = 1'b1;
        step();
        idle_inputs();
        repeat (6) step();

        // Both requesters every cycle: alternation and full back-pressure.
        for (int i = 0; i < 14; i++) begin
            itlb_valid_i = 1'b1; itlb_x_i = 1'b1; itlb_ppn_i = 20'hA0000 + 20'(i);
            ptw_valid_i  = 1'b1; ptw_x_i  = 1'b1; ptw_ppn_i  = 20'hB0000 + 20'(i);
            step();
        end
        idle_inputs();
        repeat (14) step();

        // Repeat insert of an already-known PPN, then an X=0 request.
        itlb_valid_i = 1'b1; itlb_ppn_i = 20'h00042; itlb_x_i = 1'b1;
        step();
        idle_inputs();
        repeat (4) step();
        ptw_valid_i = 1'b1; ptw_ppn_i = 20'h00042; ptw_x_i = 1'b1;
        step();
        ptw_x_i = 1'b0; ptw_ppn_i = 20'h00777;
        step();
        idle_inputs();
        repeat (6) step();

        // Continuous fetch queries with one entry pending.
        itlb_valid_i = 1'b1; itlb_ppn_i = 20'h0ABCD; itlb_x_i = 1'b1;
        fq_valid_i = 1'b1; fq_pa_i = 32'h8000_1234;
        step();
        itlb_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fq_pa_i   = $urandom();
            trk_hit_i = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Entries pending, SATP write with a concurrent ITLB request.
        for (int i = 0; i < 3; i++) begin
            itlb_valid_i = 1'b1; itlb_x_i = 1'b1; itlb_ppn_i = 20'hC0000 + 20'(i);
            step();
        end
        itlb_ppn_i = 20'hC00FF; satp_wr_i = 1'b1;
        step();
        idle_inputs();
        repeat (6) step();

        // Reset asserted while an insert is on the tracker port.
        itlb_valid_i = 1'b1; itlb_x_i = 1'b1; itlb_ppn_i = 20'hD0001;
        step();
        itlb_ppn_i = 20'hD0002;
        step();
        idle_inputs();
        for (int i = 0; i < 20 && phase != PH_INSERT; i++) step();
        check("reach_insert", phase == PH_INSERT, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (8) step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            itlb_valid_i = ($urandom_range(0, 99) < 50);
            itlb_x_i     = ($urandom_range(0, 99) < 85);
            itlb_ppn_i   = 20'($urandom_range(0, 15));
            ptw_valid_i  = ($urandom_range(0, 99) < 50);
            ptw_x_i      = ($urandom_range(0, 99) < 85);
            ptw_ppn_i    = 20'($urandom_range(0, 15));
            sfence_g_i   = ($urandom_range(0, 59) == 0);
            satp_wr_i    = ($urandom_range(0, 59) == 0);
            fq_valid_i   = ($urandom_range(0, 99) < 70);
            fq_pa_i      = $urandom();
            trk_hit_i    = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
